// File: rtl/gray_updown_counter.sv
// gray_updown_counter: binary up/down counter with load, Gray-coded view, wrap pulse and saturate flag.
module gray_updown_counter #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] SP,
  output logic [WIDTH-1:0] SF,
  output logic [WIDTH-1:0] Y,
  output logic             wrap,
  output logic             sat
);
  logic [WIDTH-1:0] sp_q, sp_d, step;
  logic             wrap_q, wrap_d, at_term;
  always_comb begin
    at_term = dir ? (sp_q == '0) : (sp_q == '1);
    step    = dir ? sp_q - WIDTH'(1) : sp_q + WIDTH'(1);
    sat     = !WRAP && en && !load && at_term;
    sp_d    = load ? din : (en && !sat) ? step : sp_q;
    wrap_d  = WRAP && en && !load && at_term;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      sp_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      wrap_q <= wrap_d;
    end
  assign SP   = sp_q;
  assign SF   = sp_d;
  assign Y    = sp_q ^ (sp_q >> 1);
  assign wrap = wrap_q;
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: random and directed checks of wrap and saturate instances against a reference model.
module tb_gray_updown_counter;
  localparam int W   = 3;
  localparam int MAX = (1 << W) - 1;
  logic         CLK = 1'b0, reset = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] sp_w, sf_w, y_w, sp_s, sf_s, y_s;
  logic         wrap_w, sat_w, wrap_s, sat_s;
  int n_chk = 0, n_fail = 0;
  int m_sp[2];
  int m_wr[2];
  int gray[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  always #5 CLK = ~CLK;
  gray_updown_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .CLK(CLK), .reset(reset), .en(en), .dir(dir), .load(load), .din(din),
    .SP(sp_w), .SF(sf_w), .Y(y_w), .wrap(wrap_w), .sat(sat_w));
  gray_updown_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
    .CLK(CLK), .reset(reset), .en(en), .dir(dir), .load(load), .din(din),
    .SP(sp_s), .SF(sf_s), .Y(y_s), .wrap(wrap_s), .sat(sat_s));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit term(input int sp);
    return (!dir && sp == MAX) || (dir && sp == 0);
  endfunction
  function automatic int nxt(input int sp, input bit w);
    if (load) return int'(din);
    if (!en) return sp;
    if (term(sp)) return w ? (dir ? MAX : 0) : sp;
    return dir ? sp - 1 : sp + 1;
  endfunction
  task automatic check_comb();
    check("SF_wrap", int'(sf_w), nxt(m_sp[1], 1'b1));
    check("SF_sat", int'(sf_s), nxt(m_sp[0], 1'b0));
    check("sat_wrap", int'(sat_w), 0);
    check("sat_sat", int'(sat_s), int'(!load && en && term(m_sp[0])));
  endtask
  task automatic check_regs();
    check("SP_wrap", int'(sp_w), m_sp[1]);
    check("Y_wrap", int'(y_w), gray[m_sp[1]]);
    check("pulse_wrap", int'(wrap_w), m_wr[1]);
    check("SP_sat", int'(sp_s), m_sp[0]);
    check("Y_sat", int'(y_s), gray[m_sp[0]]);
    check("pulse_sat", int'(wrap_s), 0);
  endtask
  task automatic step(input bit l, input bit e, input bit d, input int di);
    int n1, n0;
    bit c1;
    load = l; en = e; dir = d; din = W'(di);
    #1;
    check_comb();
    n1 = nxt(m_sp[1], 1'b1);
    n0 = nxt(m_sp[0], 1'b0);
    c1 = !l && e && term(m_sp[1]);
    @(posedge CLK);
    if (reset) begin
      m_sp[1] = n1; m_sp[0] = n0; m_wr[1] = int'(c1); m_wr[0] = 0;
    end
    @(negedge CLK);
    check_regs();
  endtask
  initial begin
    m_sp = '{0, 0};
    m_wr = '{0, 0};
    #1;
    check_regs();
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    // full up cycle: wrap pulse only after the eighth edge
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    check("wrap_after_8", int'(wrap_w), 1);
    check("Y_after_8", int'(y_w), 0);
    step(0, 1, 1, 0);
    check("down_from_0", int'(sp_w), 7);
    check("down_wrap", int'(wrap_w), 1);
    step(0, 1, 1, 0);
    check("down_next_pulse", int'(wrap_w), 0);
    step(1, 0, 0, 7);
    step(1, 1, 0, 5);
    check("load_Y", int'(y_w), 7);
    step(1, 0, 0, 7);
    step(1, 1, 0, 0);
    check("load_no_wrap", int'(wrap_w), 0);
    step(1, 0, 0, 7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("sat_hold", int'(sp_s), 7);
    step(0, 1, 1, 0);
    check("sat_release", int'(sp_s), 6);
    step(1, 0, 0, 3);
    for (int i = 0; i < 4; i++) step(0, 0, i % 2 == 0, 0);
    check("hold_Y", int'(y_s), 2);
    step(1, 0, 0, 5);
    #2 reset = 1'b0;
    #1;
    m_sp = '{0, 0};
    m_wr = '{0, 0};
    check_regs();
    step(1, 1, 0, 6);
    check("reset_SF", int'(sf_w), 6);
    reset = 1'b1;
    step(0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, ($urandom % 4) != 0, 1'($urandom % 2), int'($urandom % 8));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
